pwm_modulator: RTL and testbench

//   Consumes the shaped duty word from the envelope stage and drives the 1-bit PWM audio pin.
//   - Free-running period counter.
//   - Period and duty are double-buffered: new values take effect only at a period boundary,
//     so the envelope can update every clock without glitching the waveform.
//   - Enable/disable is graceful: the period in progress always completes before the block idles.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_modulator_if.sv | 21 ++
 rtl/pwm_modulator.sv | 104 ++++++++++
 tb/tb_pwm_modulator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM audio output stage: state encoding and default width.
package pwm_pkg;

    localparam int BW_DEFAULT = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_modulator_if.sv
// Control/status bundle between the envelope stage (master) and the PWM modulator (slave).
interface pwm_modulator_if #(
    parameter int BW = 16
);
    logic          enable_i;
    logic [BW-1:0] period_i;
    logic [BW-1:0] duty_i;
    logic          pwm_o;
    logic          period_start_o;
    logic          busy_o;

    modport master (
        output enable_i, period_i, duty_i,
        input  pwm_o, period_start_o, busy_o
    );

    modport slave (
        input  enable_i, period_i, duty_i,
        output pwm_o, period_start_o, busy_o
    );
endinterface : pwm_modulator_if

// File: rtl/pwm_modulator.sv
// Double-buffered PWM generator: period/duty are latched only at period boundaries and a
// disable request lets the running period finish before the block idles.
module pwm_modulator
    import pwm_pkg::*;
#(
    parameter int BW = BW_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pwm_modulator_if.slave  bus
);

    pwm_state_e    state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] period_q, period_d;
    logic [BW-1:0] duty_q, duty_d;
    logic          pwm_q, pwm_d;
    logic          start_q, start_d;

    logic [BW-1:0] cnt_inc;
    logic          at_wrap;
    logic          can_start;
    logic          load;

    // duty >= period naturally saturates to an all-high period with this compare.
    function automatic logic high_at(input logic [BW-1:0] pos, input logic [BW-1:0] duty);
        return pos < duty;
    endfunction

    assign cnt_inc   = cnt_q + BW'(1);
    assign at_wrap   = (state_q != S_IDLE) && (cnt_q == period_q - BW'(1));
    assign can_start = bus.enable_i && (bus.period_i != '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        duty_d   = duty_q;
        pwm_d    = pwm_q;
        start_d  = 1'b0;
        load     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                pwm_d = 1'b0;
                load  = can_start;
            end
            S_RUN, S_DRAIN: begin
                if (at_wrap) begin
                    if (can_start) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        pwm_d   = 1'b0;
                    end
                end else begin
                    cnt_d   = cnt_inc;
                    pwm_d   = high_at(cnt_inc, duty_q);
                    state_d = bus.enable_i ? S_RUN : S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pwm_d   = 1'b0;
            end
        endcase

        // New period: shadow registers take the live inputs only here.
        if (load) begin
            state_d  = S_RUN;
            period_d = bus.period_i;
            duty_d   = bus.duty_i;
            cnt_d    = '0;
            pwm_d    = high_at('0, bus.duty_i);
            start_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            start_q  <= start_d;
        end
    end

    assign bus.pwm_o          = pwm_q;
    assign bus.period_start_o = start_q;
    assign bus.busy_o         = (state_q != S_IDLE);

endmodule : pwm_modulator

// File: tb/tb_pwm_modulator.sv
// Bench for pwm_modulator at BW=8: per-cycle scoreboard of pwm/start/busy plus window counts.
module tb_pwm_modulator;

    localparam int BW = 8;

    logic clk;
    logic rst;

    pwm_modulator_if #(.BW(BW)) bus ();

    pwm_modulator #(.BW(BW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: position within the period; outputs are derived from the position.
    int m_st  = 0;
    int m_pos = 0;
    int m_len = 0;
    int m_hi  = 0;

    logic [2:0] sb[$];

    int n_start = 0;
    int n_high  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_pos = 0;
        m_len = 0;
        m_hi  = 0;
    endtask

    task automatic model_step();
        int en, per, dty;
        en  = int'(bus.enable_i);
        per = int'(bus.period_i);
        dty = int'(bus.duty_i);
        if (m_st == 0 || m_pos == m_len - 1) begin
            if (en != 0 && per != 0) begin
                m_st  = 1;
                m_pos = 0;
                m_len = per;
                m_hi  = dty;
            end else begin
                m_st  = 0;
                m_pos = 0;
            end
        end else begin
            m_pos = m_pos + 1;
            m_st  = (en != 0) ? 1 : 2;
        end
    endtask

    task automatic tick();
        logic [2:0] e;
        logic [2:0] got;
        if (!rst) model_step();
        e[2] = (m_st != 0) && (m_pos < m_hi);
        e[1] = (m_st != 0) && (m_pos == 0);
        e[0] = (m_st != 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            got = sb.pop_front();
            chk("pwm",   bus.pwm_o,          got[2]);
            chk("start", bus.period_start_o, got[1]);
            chk("busy",  bus.busy_o,         got[0]);
        end
        if (bus.period_start_o) n_start++;
        if (bus.pwm_o) n_high++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pos(input string tag, input int p);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_st != 0 && m_pos == p) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk(tag, 0, 1);
    endtask

    task automatic clr();
        n_start = 0;
        n_high  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.enable_i = 1'b0;
        bus.period_i = '0;
        bus.duty_i   = '0;
        @(posedge clk);
        #1;
        chk("rst_pwm",   bus.pwm_o,          0);
        chk("rst_start", bus.period_start_o, 0);
        chk("rst_busy",  bus.busy_o,         0);

        // 1: period 10, duty 3 from reset release
        bus.enable_i = 1'b1;
        bus.period_i = 8'd10;
        bus.duty_i   = 8'd3;
        rst          = 1'b0;
        clr();
        run(30);
        chk("t1_starts", n_start, 3);
        chk("t1_highs",  n_high,  9);

        // 2: duty 3 -> 7 at cnt 4
        wait_pos("t2_wait", 4);
        bus.duty_i = 8'd7;
        clr();
        run(5);
        chk("t2_cur_highs", n_high, 0);
        clr();
        run(10);
        chk("t2_next_highs", n_high, 7);
        chk("t2_next_start", n_start, 1);

        // 3: duty above period saturates, then duty 0
        bus.duty_i = 8'd12;
        wait_pos("t3_wait_a", 0);
        clr();
        run(10);
        chk("t3_sat_highs", n_high, 10);
        bus.duty_i = 8'd0;
        wait_pos("t3_wait_b", 0);
        clr();
        run(10);
        chk("t3_zero_highs", n_high, 0);

        // 4: graceful disable, then disable/re-enable within a period
        bus.duty_i = 8'd3;
        wait_pos("t4_wait_a", 0);
        wait_pos("t4_wait_b", 4);
        bus.enable_i = 1'b0;
        run(5);
        chk("t4_drain_busy", bus.busy_o, 1);
        run(1);
        chk("t4_idle_busy", bus.busy_o, 0);
        chk("t4_idle_pwm",  bus.pwm_o,  0);
        bus.enable_i = 1'b1;
        wait_pos("t4_wait_c", 4);
        bus.enable_i = 1'b0;
        wait_pos("t4_wait_d", 7);
        bus.enable_i = 1'b1;
        clr();
        run(2);
        chk("t4_no_early_start", n_start, 0);
        run(1);
        chk("t4_wrap_start", n_start, 1);
        run(10);

        // 5: period 0 keeps the block idle, then period 1 duty 1
        bus.period_i = 8'd0;
        run(15);
        clr();
        run(10);
        chk("t5_idle_starts", n_start, 0);
        chk("t5_idle_busy",   bus.busy_o, 0);
        bus.period_i = 8'd1;
        bus.duty_i   = 8'd1;
        clr();
        run(10);
        chk("t5_p1_starts", n_start, 10);
        chk("t5_p1_highs",  n_high,  10);

        // 6: reset in the high phase
        bus.period_i = 8'd10;
        bus.duty_i   = 8'd3;
        wait_pos("t6_wait", 1);
        chk("t6_pre_pwm", bus.pwm_o, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_pwm",   bus.pwm_o,          0);
        chk("t6_rst_start", bus.period_start_o, 0);
        chk("t6_rst_busy",  bus.busy_o,         0);
        model_reset();
        run(2);
        rst = 1'b0;
        clr();
        run(1);
        chk("t6_restart", n_start, 1);
        run(19);
        chk("t6_highs", n_high, 6);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pwm_modulator
